// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: byte-wide memory-mapped UART transmitter.
// CPU writes to the data address are queued in a small FIFO and shifted out
// as 8N1 frames on O_TX. The status byte at BASE_ADDR+1 is read back
// combinationally so software can poll FULL/BUSY/OVR before pushing.
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
  parameter int          CLK_DIV    = 217,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [15:0] I_ADDR,
  input  logic [7:0]  I_DATA,
  input  logic        I_WREN,
  output logic [7:0]  O_DATA,
  output logic        O_SEL,
  output logic        O_TX
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [15:0]       STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_TOP  = BAUD_W'(CLK_DIV - 1);
  localparam logic [2:0]        LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Bus decode
  logic hit_data;
  logic hit_stat;
  logic push_req;
  logic push_ok;
  logic ovr_clr;

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;

  // Sticky overrun flag
  logic ovr;

  // Transmitter state
  state_t            state;
  state_t            state_n;
  logic [7:0]        shift_q;
  logic [7:0]        shift_n;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_n;
  logic [2:0]        idx_q;
  logic [2:0]        idx_n;
  logic              tx_n;
  logic              baud_done;
  logic              busy;

  logic [7:0] status;

  assign hit_data = (I_ADDR == BASE_ADDR);
  assign hit_stat = (I_ADDR == STAT_ADDR);
  assign push_req = I_WREN && hit_data;
  // A push against a full FIFO is dropped even if the transmitter pops in
  // the same cycle; the slot freed by that pop is not reused until later.
  assign push_ok  = push_req && !fifo_full;
  assign ovr_clr  = I_WREN && hit_stat && I_DATA[3];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign baud_done  = (baud_q == '0);
  assign busy       = (state != S_IDLE);

  assign status = {4'b0000, ovr, busy, fifo_full, fifo_empty};

  // Read path: purely combinational on the address so the core sees it in
  // the same cycle it drives I_ADDR.
  always_comb begin
    O_SEL  = hit_data || hit_stat;
    O_DATA = 8'h00;
    if (hit_stat) begin
      O_DATA = status;
    end
  end

  // FIFO storage write; contents are not reset, only the pointers are.
  always_ff @(posedge CLOCK) begin
    if (push_ok && !RESET) begin
      fifo_mem[wr_ptr] <= I_DATA;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overrun flag; a set wins over a clear in the same cycle.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ovr <= 1'b0;
    end else if (push_req && fifo_full) begin
      ovr <= 1'b1;
    end else if (ovr_clr) begin
      ovr <= 1'b0;
    end
  end

  // Transmitter next-state logic; O_TX is derived from the next state so
  // the pin is a plain register with no extra cycle of lag.
  always_comb begin
    state_n = state;
    shift_n = shift_q;
    baud_n  = baud_q;
    idx_n   = idx_q;
    pop     = 1'b0;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_mem[rd_ptr];
          baud_n  = BAUD_TOP;
          state_n = S_START;
        end
      end

      S_START: begin
        if (baud_done) begin
          baud_n  = BAUD_TOP;
          idx_n   = 3'd0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_q - BAUD_W'(1);
        end
      end

      S_DATA: begin
        if (baud_done) begin
          baud_n  = BAUD_TOP;
          shift_n = shift_q >> 1;
          if (idx_q == LAST_BIT) begin
            state_n = S_STOP;
          end else begin
            idx_n = idx_q + 3'd1;
          end
        end else begin
          baud_n = baud_q - BAUD_W'(1);
        end
      end

      S_STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit when data is waiting,
          // so queued bytes go out back-to-back.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_mem[rd_ptr];
            baud_n  = BAUD_TOP;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_q - BAUD_W'(1);
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  // Transmitter state register; reset aborts any frame in flight.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state   <= S_IDLE;
      shift_q <= 8'h00;
      baud_q  <= '0;
      idx_q   <= 3'd0;
      O_TX    <= 1'b1;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      baud_q  <= baud_n;
      idx_q   <= idx_n;
      O_TX    <= tx_n;
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped serial transmitter on the 8-bit CPU data bus, downstream of the CPU core. Consumes the core's byte writes (address, write data, write enable), buffers them in a small FIFO and shifts them out as 8N1 frames on a TX pin. A status byte is read back combinationally through the top-level read mux. Software polls it before pushing.

## Interface
- BASE_ADDR, 16'hFFF0: data register at BASE_ADDR, status/control at BASE_ADDR+1
- CLK_DIV, 217: clock cycles per serial bit (25 MHz / 115200); legal range 2..65535
- FIFO_DEPTH, 16: FIFO entries; power of two, 2..256

- CLOCK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- I_ADDR  in  16  CPU bus address (core's O_ADDR)
- I_DATA  in  8  CPU write data (core's O_DATA)
- I_WREN  in  1  CPU write enable (core's O_WREN)
- O_DATA  out  8  read data; combinational from I_ADDR
- O_SEL  out  1  high when I_ADDR is BASE_ADDR or BASE_ADDR+1; top level uses it to route O_DATA to the core's I_DATA instead of RAM
- O_TX  out  1  serial output, registered, idle high

## Operation
- Write to BASE_ADDR:
  - Each cycle with I_WREN=1 and I_ADDR==BASE_ADDR pushes I_DATA once.
  - A write held for N cycles pushes N copies. The core never does this to one address.
- Push while full (count==FIFO_DEPTH before the edge):
  - The byte is dropped and sticky OVR is set.
  - This holds even when a pop happens in the same cycle.
- Write to BASE_ADDR+1: if I_DATA[3]=1, OVR is cleared. All other bits are ignored. A set and a clear of OVR in the same cycle leave OVR set.
- Read of BASE_ADDR+1 gives status {4'b0, OVR, BUSY, FULL, EMPTY}.
  - EMPTY: count==0.
  - FULL: count==FIFO_DEPTH.
  - BUSY: FSM not in IDLE.
- Read of BASE_ADDR gives 8'h00. O_DATA=8'h00 whenever O_SEL=0.
- FIFO:
  - Circular read and write pointers, log2(FIFO_DEPTH) bits, wrapping modulo depth.
  - Separate count, log2(FIFO_DEPTH)+1 bits.
  - Simultaneous push and pop when not full: count unchanged and both pointers advance.
- TX FSM:
  - IDLE: O_TX=1. If FIFO is non-empty, pop into an 8-bit shift register, load the baud counter, go to START.
  - START: O_TX=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: O_TX=shift[0] for CLK_DIV cycles per bit, LSB first. Shift right after each bit. After bit 7 go to STOP.
  - STOP: O_TX=1 for CLK_DIV cycles. On the last stop cycle:
    - FIFO non-empty: pop and go directly to START, giving back-to-back frames with no extra idle cycle.
    - Otherwise go to IDLE.
- Baud counter counts CLK_DIV-1 down to 0, and the bit advances on 0. Width is ceil(log2(CLK_DIV)).
- Reset:
  - FSM=IDLE, O_TX=1, pointers=0, count=0, OVR=0, shift register=0, baud counter=0.
  - Reset mid-frame aborts the frame. O_TX is high after the reset edge and no stop-bit completion occurs.
  - Pushes during RESET are ignored.

## Timing
- Write latency: a push sampled at edge E is visible in status (EMPTY=0) in the cycle after E.
- From IDLE with an empty FIFO, a push sampled at edge E is popped at edge E+1.
- O_TX falls after edge E+1 and stays low for exactly CLK_DIV cycles.
- One frame is exactly 10*CLK_DIV cycles from O_TX falling to the end of the stop bit.
- BUSY=1 from the cycle after the pop until the cycle after the last stop cycle, when no further byte is queued.
- O_DATA and O_SEL are purely combinational on I_ADDR, so the core can read them in the same cycle the address is presented.

## Test plan
- Reset value: assert RESET 2 cycles, then hold I_ADDR=BASE_ADDR+1 -> O_SEL=1, O_DATA=8'h01, O_TX=1. Assert RESET mid-frame -> O_TX=1 on the next cycle and status 8'h01.
- Single frame, CLK_DIV=4: write 8'hA5 -> O_TX low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. Total 40 cycles. BUSY clears after the frame and status returns to 8'h01.
- Back-to-back: push 8'h00 and 8'hFF on consecutive cycles -> second start bit begins immediately after the first stop bit, with no idle cycle. Both frames decode correctly.
- Overflow, FIFO_DEPTH=4, CLK_DIV=100: push 6 bytes 8'h10..8'h15 in 6 consecutive cycles. After the 6th write, status shows FULL=1, OVR=1, BUSY=1 (8'h0E). Only 8'h10..8'h14 are transmitted; 8'h15 is dropped. Writing 8'h08 to BASE_ADDR+1 clears OVR.
- Pointer wrap: push and drain 20 bytes 8'h00..8'h13 with FIFO_DEPTH=4 -> output order preserved across wraps and EMPTY=1 at the end.
- Decode: I_WREN at BASE_ADDR-1 and BASE_ADDR+2 -> no push, O_SEL=0, O_DATA=8'h00.
